// File: rtl/cpu_0_div_cell.sv
// cpu_0_div_cell
//   Iterative radix-2 restoring divider for the A-stage divide instructions.
//   One quotient bit per clock; fixed WIDTH+2 cycle latency from start to done.
//   Signed operation divides magnitudes, then fixes the result signs: the
//   quotient is negative when the operand signs differ, and the remainder
//   takes the dividend's sign.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   A_div_start  one-cycle request, operands sampled on this edge (ignored while busy)
//   A_div_signed 1 = two's-complement operands, 0 = unsigned
//   A_div_src1   dividend
//   A_div_src2   divisor
//   A_div_busy   high while RUN or FIX is in progress
//   A_div_done   one-cycle pulse, results valid from this cycle
//   A_div_quot   quotient, held until the next done
//   A_div_rem    remainder, held until the next done
module cpu_0_div_cell #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             A_div_start,
   input  logic             A_div_signed,
   input  logic [WIDTH-1:0] A_div_src1,
   input  logic [WIDTH-1:0] A_div_src2,
   output logic             A_div_busy,
   output logic             A_div_done,
   output logic [WIDTH-1:0] A_div_quot,
   output logic [WIDTH-1:0] A_div_rem
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] divd;    // dividend magnitude, shifts out MSB-first, quotient shifts in
   logic [WIDTH-1:0] dvsr;    // divisor magnitude
   logic [WIDTH-1:0] prem;    // partial remainder
   logic [CW-1:0]    cnt;
   logic             neg_q;
   logic             neg_r;

   // Operand magnitudes for the start cycle
   logic [WIDTH-1:0] mag1, mag2;
   assign mag1 = (A_div_signed && A_div_src1[WIDTH-1]) ? -A_div_src1 : A_div_src1;
   assign mag2 = (A_div_signed && A_div_src2[WIDTH-1]) ? -A_div_src2 : A_div_src2;

   // One restoring step. The shifted remainder needs WIDTH+1 bits; since
   // prem < dvsr, a set top bit always implies a non-negative trial.
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] trial;
   assign rem_sh = {prem, divd[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, dvsr};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         divd       <= '0;
         dvsr       <= '0;
         prem       <= '0;
         cnt        <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         A_div_done <= 1'b0;
         A_div_quot <= '0;
         A_div_rem  <= '0;
      end else begin
         A_div_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (A_div_start) begin
                  divd  <= mag1;
                  dvsr  <= mag2;
                  prem  <= '0;
                  cnt   <= CW'(WIDTH - 1);
                  neg_q <= A_div_signed & (A_div_src1[WIDTH-1] ^ A_div_src2[WIDTH-1]);
                  neg_r <= A_div_signed & A_div_src1[WIDTH-1];
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (!trial[WIDTH]) begin
                  prem <= trial[WIDTH-1:0];
                  divd <= {divd[WIDTH-2:0], 1'b1};
               end else begin
                  prem <= rem_sh[WIDTH-1:0];
                  divd <= {divd[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt - 1'b1;
               if (cnt == '0)
                  state <= S_FIX;
            end
            S_FIX: begin
               A_div_quot <= neg_q ? -divd : divd;
               A_div_rem  <= neg_r ? -prem : prem;
               A_div_done <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign A_div_busy = (state != S_IDLE);

endmodule

// File: tb/tb_cpu_0_div_cell.sv
module tb_cpu_0_div_cell;
   localparam int WIDTH = 32;
   localparam int LAT   = WIDTH + 2;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic             sg = 1'b0;
   logic [WIDTH-1:0] src1 = '0;
   logic [WIDTH-1:0] src2 = '0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;

   int checks   = 0;
   int failures = 0;

   cpu_0_div_cell #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .A_div_start  (start),
      .A_div_signed (sg),
      .A_div_src1   (src1),
      .A_div_src2   (src2),
      .A_div_busy   (busy),
      .A_div_done   (done),
      .A_div_quot   (quot),
      .A_div_rem    (rem)
   );

   always #5 clk = ~clk;

   // Reference: plain integer division with C-style truncation; divide by
   // zero gives all-ones magnitude quotient and the dividend as remainder.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r);
      longint sa, sb, qq, rr;
      if (!s) begin
         if (b == 0) begin q = '1; r = a; end
         else begin q = a / b; r = a % b; end
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         if (sb == 0) begin
            qq = (sa < 0) ? 1 : -1;
            rr = sa;
         end else begin
            qq = sa / sb;
            rr = sa % sb;
         end
         q = qq[31:0];
         r = rr[31:0];
      end
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || quot !== '0 || rem !== '0) begin
         failures++;
         $display("FAIL reset_state busy=%b done=%b quot=%h rem=%h want 0/0/0/0", busy, done, quot, rem);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Issue one operation and check busy profile, latency, results and hold.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
      logic [31:0] eq, er;
      int bad;
      model(a, b, s, eq, er);
      @(negedge clk);
      start = 1'b1; sg = s; src1 = a; src2 = b;
      @(negedge clk);
      start = 1'b0; src1 = $urandom; src2 = $urandom; sg = 1'($urandom);
      bad = 0;
      for (int c = 1; c <= LAT - 1; c++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL %s busy_profile bad_cycles=%0d want 0", tag, bad);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s done_cycle done=%b busy=%b want 1/0", tag, done, busy);
      end
      checks++;
      if (quot !== eq || rem !== er) begin
         failures++;
         $display("FAIL %s result quot=%h rem=%h want %h/%h", tag, quot, rem, eq, er);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || quot !== eq || rem !== er) begin
         failures++;
         $display("FAIL %s hold done=%b quot=%h rem=%h want 0/%h/%h", tag, done, quot, rem, eq, er);
      end
   endtask

   task automatic test_directed();
      run_op(32'd100, 32'd7, 1'b0, "u100_7");
      run_op(-32'sd7, 32'd2, 1'b1, "s-7_2");
      run_op(32'd7, -32'sd2, 1'b1, "s7_-2");
      run_op(32'h1234, 32'd0, 1'b0, "u_div0");
      run_op(-32'sd5, 32'd0, 1'b1, "s_div0");
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "u_max_1");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_max_max");
      run_op(32'd3, 32'd10, 1'b0, "u_small");
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         if (i % 5 == 0) b = b >> $urandom_range(0, 31);
         run_op(a, b, 1'($urandom), $sformatf("rand%0d", i));
      end
   endtask

   // Starts at cycles 5 and 20 are ignored; a start in the done cycle is taken.
   task automatic test_back_to_back();
      logic [31:0] a [2], b [2], eq, er;
      logic        s [2];
      int bad;
      a[0] = 32'd1000; b[0] = 32'd33; s[0] = 1'b0;
      a[1] = -32'sd999; b[1] = 32'd10; s[1] = 1'b1;
      @(negedge clk);
      start = 1'b1; sg = s[0]; src1 = a[0]; src2 = b[0];
      for (int k = 0; k < 2; k++) begin
         model(a[k], b[k], s[k], eq, er);
         @(negedge clk);
         bad = 0;
         for (int c = 1; c <= LAT - 1; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (k == 0 && (c == 5 || c == 20)) begin
               start = 1'b1; sg = 1'b0; src1 = 32'd5; src2 = 32'd1;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
         end
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL b2b%0d busy_profile bad_cycles=%0d want 0", k, bad);
         end
         checks++;
         if (done !== 1'b1 || busy !== 1'b0 || quot !== eq || rem !== er) begin
            failures++;
            $display("FAIL b2b%0d done=%b busy=%b quot=%h rem=%h want 1/0/%h/%h", k, done, busy, quot, rem, eq, er);
         end
         if (k == 0) begin
            start = 1'b1; sg = s[1]; src1 = a[1]; src2 = b[1];
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_single_pulse done=%b want 0", done);
      end
   endtask

   task automatic test_reset_midop();
      int seen;
      @(negedge clk);
      start = 1'b1; sg = 1'b0; src1 = 32'd12345; src2 = 32'd17;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || quot !== '0 || rem !== '0) begin
         failures++;
         $display("FAIL reset_midop busy=%b done=%b quot=%h rem=%h want 0/0/0/0", busy, done, quot, rem);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int c = 0; c < LAT + 6; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL reset_discard activity_cycles=%0d want 0", seen);
      end
      run_op(32'd9, 32'd3, 1'b0, "post_reset_9_3");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
